// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit.
// Takes one M-extension op at a time over a valid/ready handshake, runs an
// unsigned shift-add multiply or restoring divide on operand magnitudes
// (UNROLL bits per cycle), applies sign correction and holds the result until
// the consumer accepts it. Division-by-zero and signed-overflow divides skip
// the iterative phase entirely.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   flush      abort any in-flight op; wins over a new accept
//   in_valid   op/a/b valid
//   in_ready   unit idle and able to accept
//   op         funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   a, b       rs1 / rs2 operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     registered result
//   z_flag     registered (result == 0)
module alu_muldiv #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z_flag
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       op_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Operand decode at accept time
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_by_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_result;

  assign a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                    (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b000) || (op == 3'b001) ||
                    (op == 3'b100) || (op == 3'b110);
  assign a_neg    = a_signed && a[WIDTH-1];
  assign b_neg    = b_signed && b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  assign div_by_zero = op[2] && (b == '0);
  assign div_ovf     = ((op == 3'b100) || (op == 3'b110)) &&
                       (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign fast        = div_by_zero || div_ovf;

  // op[1] selects remainder among the divide ops; overflow remainder is zero
  always_comb begin
    fast_result = '1;
    if (op[1]) fast_result = div_ovf ? '0 : a;
    else       fast_result = div_ovf ? a : '1;
  end

  // UNROLL chained iterations. Multiply: {hi,lo} holds partial product with
  // the multiplier shifting out of lo. Divide: hi is the partial remainder and
  // lo shifts the dividend out while the quotient bits shift in.
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   shifted, diff, sum;

  always_comb begin
    step_hi = hi;
    step_lo = lo;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_r[2]) begin
        shifted = {step_hi, step_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        // diff MSB set means the trial subtraction borrowed: restore
        if (!diff[WIDTH]) begin
          step_hi = diff[WIDTH-1:0];
          step_lo = {step_lo[WIDTH-2:0], 1'b1};
        end else begin
          step_hi = shifted[WIDTH-1:0];
          step_lo = {step_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        step_lo = {sum[0], step_lo[WIDTH-1:1]};
        step_hi = sum[WIDTH:1];
      end
    end
  end

  // Sign correction applied to the output of the final iteration
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_result;

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -step_lo : step_lo;
    rem_s  = neg_r ? -step_hi : step_hi;
    final_result = '0;
    if (op_r[2])              final_result = op_r[1] ? rem_s : quo_s;
    else if (op_r == 3'b000)  final_result = prod_s[WIDTH-1:0];
    else                      final_result = prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      z_flag    <= 1'b1;
      count     <= '0;
      op_r      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op_r     <= op;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            if (fast) begin
              result    <= fast_result;
              z_flag    <= (fast_result == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // Multiply iterates over b with a as multiplicand; divide over a
              hi    <= '0;
              lo    <= op[2] ? a_mag : b_mag;
              opb   <= op[2] ? b_mag : a_mag;
              count <= CW'(STEPS);
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result    <= final_result;
            z_flag    <= (final_result == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: drives three alu_muldiv instances (UNROLL 1, 2, 4) with the
// same op stream and checks results, zero flag, latency and handshake against
// an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready_v [3];
  logic        out_valid_v[3];
  logic        z_v        [3];
  logic [31:0] result_v   [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32), .UNROLL(1)) u_unroll1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .op(op), .a(a), .b(b),
    .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .result(result_v[0]), .z_flag(z_v[0]));

  alu_muldiv #(.WIDTH(32), .UNROLL(2)) u_unroll2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .op(op), .a(a), .b(b),
    .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .result(result_v[1]), .z_flag(z_v[1]));

  alu_muldiv #(.WIDTH(32), .UNROLL(4)) u_unroll4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .op(op), .a(a), .b(b),
    .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .result(result_v[2]), .z_flag(z_v[2]));

  // Reference model straight from the RV32M arithmetic definitions
  function automatic logic [31:0] model(input logic [2:0] m_op, input logic [31:0] m_a, m_b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(m_a));
    sb  = longint'($signed(m_b));
    ua  = longint'({32'b0, m_a});
    ub  = longint'({32'b0, m_b});
    ovf = (m_a == 32'h8000_0000) && (m_b == 32'hFFFF_FFFF);
    case (m_op)
      3'b000:  begin p = 64'(sa * sb); return p[31:0];  end
      3'b001:  begin p = 64'(sa * sb); return p[63:32]; end
      3'b010:  begin p = 64'(sa * ub); return p[63:32]; end
      3'b011:  begin p = 64'(ua * ub); return p[63:32]; end
      3'b100:  begin
        if (m_b == 0) return 32'hFFFF_FFFF;
        if (ovf) return m_a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'b101:  return (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
      3'b110:  begin
        if (m_b == 0) return m_a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (m_b == 0) ? m_a : m_a % m_b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleAll(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s_out_valid_u%0d", tag, 1 << k), {31'b0, out_valid_v[k]}, 32'd0);
      checkOutput($sformatf("%s_in_ready_u%0d", tag, 1 << k), {31'b0, in_ready_v[k]}, 32'd1);
    end
  endtask

  // Issue one op to all instances, measure latency, check, then drain
  task automatic applyStimulus(input logic [2:0] t_op, input logic [31:0] t_a, t_b, input int hold);
    logic [31:0] exp;
    int          lat[3];
    int          cyc;
    int          exp_lat;
    bit          fast;
    exp  = model(t_op, t_a, t_b);
    fast = t_op[2] && ((t_b == 0) ||
           (!t_op[0] && t_a == 32'h8000_0000 && t_b == 32'hFFFF_FFFF));
    cyc = 0;
    while (!(in_ready_v[0] && in_ready_v[1] && in_ready_v[2]) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("ready_before_issue",
                {31'b0, in_ready_v[0] && in_ready_v[1] && in_ready_v[2]}, 32'd1);
    op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
    lat = '{0, 0, 0};
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        // Inputs change while busy and must be ignored
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      end
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && out_valid_v[k]) lat[k] = cyc;
    end while (!(lat[0] != 0 && lat[1] != 0 && lat[2] != 0) && cyc < 60);
    for (int k = 0; k < 3; k++) begin
      exp_lat = fast ? 1 : 32 / (1 << k) + 1;
      checkOutput($sformatf("latency_u%0d_op%0d", 1 << k, t_op), 32'(lat[k]), 32'(exp_lat));
      checkOutput($sformatf("result_u%0d_op%0d", 1 << k, t_op), result_v[k], exp);
      checkOutput($sformatf("z_flag_u%0d_op%0d", 1 << k, t_op), {31'b0, z_v[k]}, {31'b0, exp == 0});
      checkOutput($sformatf("busy_in_ready_u%0d", 1 << k), {31'b0, in_ready_v[k]}, 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_result", result_v[0], exp);
      checkOutput("hold_out_valid", {31'b0, out_valid_v[0]}, 32'd1);
      checkOutput("hold_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkIdleAll("drain");
  endtask

  task automatic checkReset(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s_in_ready_u%0d", tag, 1 << k), {31'b0, in_ready_v[k]}, 32'd1);
      checkOutput($sformatf("%s_out_valid_u%0d", tag, 1 << k), {31'b0, out_valid_v[k]}, 32'd0);
      checkOutput($sformatf("%s_result_u%0d", tag, 1 << k), result_v[k], 32'd0);
      checkOutput($sformatf("%s_z_flag_u%0d", tag, 1 << k), {31'b0, z_v[k]}, 32'd1);
    end
  endtask

  function automatic logic [31:0] pickOperand(input int sel);
    case (sel)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("por");
    rst_n = 1'b1;

    // Directed arithmetic cases
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b000, 32'd0, 32'd5, 0);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus(3'b111, 32'd10, 32'd3, 0);

    // Fast paths
    applyStimulus(3'b100, 32'd5, 32'd0, 0);
    applyStimulus(3'b111, 32'd5, 32'd0, 0);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Consumer stall in DONE
    applyStimulus(3'b001, 32'h1234_5678, 32'hDEAD_BEEF, 5);

    // Flush while all instances are still iterating
    op = 3'b101; a = 32'hFFFF_0000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkIdleAll("flush");
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid_v[0] || out_valid_v[1] || out_valid_v[2]) seen = 1'b1;
    end
    checkOutput("flush_no_out_valid", {31'b0, seen}, 32'd0);
    applyStimulus(3'b101, 32'hFFFF_0000, 32'd7, 0);

    // Flush beats a simultaneous request in IDLE
    op = 3'b000; a = 32'd3; b = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkIdleAll("flush_idle");
    repeat (3) begin @(posedge clk); #1; end
    checkIdleAll("flush_idle_later");

    // Reset in the middle of CALC
    op = 3'b001; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkReset("mid_reset");
    applyStimulus(3'b100, 32'd100, 32'hFFFF_FFF9, 0);

    // Randomised back-to-back ops biased toward boundary operands
    for (int n = 0; n < 30; n++)
      applyStimulus(3'($urandom_range(0, 7)), pickOperand($urandom_range(0, 6)),
                    pickOperand($urandom_range(0, 6)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
